// File: rtl/riscv_mc_ctrl_if.sv
// riscv_mc_ctrl_if: control bus between the multicycle RV32I controller and
// its datapath.
//
// Signals:
//   mem_ready              memory finished the current fetch/read/write
//   zero, lt, ltu          flags from the ALU rs1-rs2 compare
//   opcode, funct3, funct7 instruction-register fields
//   pc_write, adr_src, mem_write, ir_write, reg_write, branch   enables/selects
//   imm_src[2:0]           000 I, 001 S, 010 B, 011 J, 100 U
//   alu_src_a[1:0]         00 PC, 01 OldPC, 10 rs1
//   alu_src_b[1:0]         00 rs2, 01 imm, 10 const 4
//   result_src[1:0]        00 ALUOut, 01 Data, 10 ALUResult
//   alu_ctrl               ALU opcode, ALU_CTRL_W bits, upper bits zero
//   trap, trap_cause[1:0]  trap flag and registered cause (01 illegal, 10 timeout)
//
// Modports: master = controller side, slave = datapath side.
// Handshake: there is no valid/ready pair on this bus. mem_ready is a
// single-cycle completion strobe from memory; the controller holds its
// request (adr_src/mem_write) until it sees mem_ready=1 at a rising edge.
interface riscv_mc_ctrl_if #(
    parameter int ALU_CTRL_W = 4
);
    logic                  mem_ready;
    logic                  zero;
    logic                  lt;
    logic                  ltu;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;

    logic                  pc_write;
    logic                  adr_src;
    logic                  mem_write;
    logic                  ir_write;
    logic                  reg_write;
    logic                  branch;
    logic [2:0]            imm_src;
    logic [1:0]            alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            result_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  trap;
    logic [1:0]            trap_cause;

    modport master (
        input  mem_ready, zero, lt, ltu, opcode, funct3, funct7,
        output pc_write, adr_src, mem_write, ir_write, reg_write, branch,
               imm_src, alu_src_a, alu_src_b, result_src, alu_ctrl,
               trap, trap_cause
    );

    modport slave (
        output mem_ready, zero, lt, ltu, opcode, funct3, funct7,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, branch,
               imm_src, alu_src_a, alu_src_b, result_src, alu_ctrl,
               trap, trap_cause
    );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multicycle RV32I control FSM. Drives every mux select,
// write enable and ALU opcode of the multicycle datapath from the IR fields,
// waits on a variable-latency memory with a timeout, and parks in a sticky
// TRAP state on illegal instructions or memory timeouts.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-low reset
//   bus      riscv_mc_ctrl_if.master (IR fields, flags, mem_ready in;
//            all controls, trap and trap_cause out)
//   state_o  current FSM state (debug visibility, encoding of state_t)
//
// Parameters:
//   ALU_CTRL_W  ALU opcode width (>= 4), upper bits driven 0
//   WAIT_MAX    max cycles waiting for mem_ready before trapping (0 = off)
//   CNT_W       wait-counter width, 2^CNT_W > WAIT_MAX
//
// Build option:
//   RV_MUL_EN   when defined, R-type funct7=01/funct3=000 decodes to MUL;
//               otherwise funct7=01 is an illegal instruction.
//
// Outputs are Moore decodes of the state register, except ir_write/pc_write
// in FETCH (gated by mem_ready) and branch in BRANCH (from the flags).
module riscv_mc_ctrl #(
    parameter int ALU_CTRL_W = 4,
    parameter int WAIT_MAX   = 15,
    parameter int CNT_W      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    riscv_mc_ctrl_if.master        bus,
    output logic [3:0]             state_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_JAL       = 4'd9,
        S_JALR_ADDR = 4'd10,
        S_JALR_LINK = 4'd11,
        S_BRANCH    = 4'd12,
        S_LUI       = 4'd13,
        S_AUIPC     = 4'd14,
        S_TRAP      = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_PASSB = 4'd11
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(WAIT_MAX);
    localparam bit               TIMEOUT_EN = (WAIT_MAX != 0);

`ifdef RV_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        cause_q, cause_d;

    logic              timeout;
    logic              r_legal;
    logic              br_legal;

    // Output locals
    logic                  pc_write, adr_src, mem_write, ir_write, reg_write, branch;
    logic [2:0]            imm_src;
    logic [1:0]            alu_src_a, alu_src_b, result_src;
    alu_op_t               alu_op;
    logic [ALU_CTRL_W-1:0] alu_ctrl;

    function automatic logic is_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WR);
    endfunction

    // Shared funct3 decode for R and I types; the callers decide what selects
    // SUB, SRA and MUL.
    function automatic alu_op_t alu_decode(input logic [2:0] f3,
                                           input logic sub_sel,
                                           input logic sra_sel,
                                           input logic mul_sel);
        alu_op_t op;
        case (f3)
            3'b000:  op = sub_sel ? ALU_SUB : (mul_sel ? ALU_MUL : ALU_ADD);
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sra_sel ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Legality checks evaluated during DECODE.
    always_comb begin
        r_legal  = (bus.funct7 == 7'h00)
                || ((bus.funct7 == 7'h20) && ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101)))
                || (MUL_EN && (bus.funct7 == 7'h01) && (bus.funct3 == 3'b000));
        br_legal = (bus.funct3 != 3'b010) && (bus.funct3 != 3'b011);
    end

    // mem_ready in the same cycle wins over the timeout.
    assign timeout = TIMEOUT_EN && (cnt_q == WAIT_MAX_C) && !bus.mem_ready;

    // Next-state, trap cause and wait counter.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                state_d = S_TRAP;
                cause_d = CAUSE_ILLEGAL;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: begin state_d = S_MEM_ADDR;  cause_d = cause_q; end
                    OP_I:              begin state_d = S_EXEC_I;    cause_d = cause_q; end
                    OP_JAL:            begin state_d = S_JAL;       cause_d = cause_q; end
                    OP_JALR:           begin state_d = S_JALR_ADDR; cause_d = cause_q; end
                    OP_LUI:            begin state_d = S_LUI;       cause_d = cause_q; end
                    OP_AUIPC:          begin state_d = S_AUIPC;     cause_d = cause_q; end
                    OP_R: begin
                        if (r_legal) begin
                            state_d = S_EXEC_R;
                            cause_d = cause_q;
                        end
                    end
                    OP_BRANCH: begin
                        if (br_legal) begin
                            state_d = S_BRANCH;
                            cause_d = cause_q;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM_ADDR: state_d = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_READ;
            S_MEM_READ: begin
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_EXEC_R,
            S_EXEC_I,
            S_JAL,
            S_JALR_LINK,
            S_LUI,
            S_AUIPC:     state_d = S_ALU_WB;
            S_JALR_ADDR: state_d = S_JALR_LINK;
            S_ALU_WB,
            S_BRANCH:    state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase

        // The counter restarts on entry to any wait state and counts idle
        // mem_ready cycles while inside one.
        cnt_d = cnt_q;
        if ((state_d != state_q) && is_wait(state_d)) begin
            cnt_d = '0;
        end else if (is_wait(state_q) && !bus.mem_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Output decode. Everything not named for a state stays 0.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        imm_src    = IMM_I;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.opcode)
                    OP_STORE:        imm_src = IMM_S;
                    OP_BRANCH:       imm_src = IMM_B;
                    OP_JAL:          imm_src = IMM_J;
                    OP_LUI, OP_AUIPC: imm_src = IMM_U;
                    default:         imm_src = IMM_I;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_READ: adr_src = 1'b1;
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
            end
            S_MEM_WR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = alu_decode(bus.funct3, bus.funct7 == 7'h20, bus.funct7 == 7'h20,
                                       MUL_EN && (bus.funct7 == 7'h01));
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = alu_decode(bus.funct3, 1'b0, bus.funct7[5], 1'b0);
            end
            S_ALU_WB: reg_write = 1'b1;
            S_JAL, S_JALR_LINK: begin
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_JALR_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_SUB;
                case (bus.funct3)
                    3'b000:  branch = bus.zero;
                    3'b001:  branch = !bus.zero;
                    3'b100:  branch = bus.lt;
                    3'b101:  branch = !bus.lt;
                    3'b110:  branch = bus.ltu;
                    3'b111:  branch = !bus.ltu;
                    default: branch = 1'b0;
                endcase
            end
            S_LUI: begin
                alu_src_b = 2'b01;
                imm_src   = IMM_U;
                alu_op    = ALU_PASSB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = IMM_U;
            end
            default: ;
        endcase

        alu_ctrl      = '0;
        alu_ctrl[3:0] = alu_op;
    end

    assign bus.pc_write   = pc_write;
    assign bus.adr_src    = adr_src;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_write  = reg_write;
    assign bus.branch     = branch;
    assign bus.imm_src    = imm_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.result_src = result_src;
    assign bus.alu_ctrl   = alu_ctrl;
    assign bus.trap       = (state_q == S_TRAP);
    assign bus.trap_cause = cause_q;
    assign state_o        = state_q;

endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Parametrised multicycle RV32I control FSM. It sits between the instruction register and the multicycle datapath, and drives every mux select, write enable and ALU opcode. It extends the previous controller in four ways:
- full ALU decode from funct3/funct7;
- all six branch conditions, plus LUI;
- a variable-latency memory handshake with a timeout;
- a sticky trap state for illegal instructions.

## Interface
- `ALU_CTRL_W`, 4 — ALU opcode width; must be ≥4. Upper bits are driven 0.
- `WAIT_MAX`, 15 — maximum cycles to wait for `mem_ready` before trapping. 0 disables the timeout.
- `CNT_W`, 4 — wait-counter width; must satisfy 2^CNT_W > WAIT_MAX.
- `clk` in 1 — clock; all state changes on the rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `mem_ready` in 1 — memory has completed the current fetch/read/write this cycle.
- `zero`, `lt`, `ltu` in 1 each — ALU flags from the rs1−rs2 compare.
- `opcode` in 7, `funct3` in 3, `funct7` in 7 — fields from the IR.
- `pc_write`, `adr_src`, `mem_write`, `ir_write`, `reg_write`, `branch` out 1 each.
- `imm_src` out 3 — 000 I, 001 S, 010 B, 011 J, 100 U.
- `alu_src_a` out 2 — 00 PC, 01 OldPC, 10 rs1.
- `alu_src_b` out 2 — 00 rs2, 01 imm, 10 const 4.
- `result_src` out 2 — 00 ALUOut, 01 Data, 10 ALUResult.
- `alu_ctrl` out ALU_CTRL_W — ALU opcode (see encoding below).
- `trap` out 1 — set while in TRAP.
- `trap_cause` out 2 — 01 illegal instruction, 10 memory timeout; registered.

## Operation
- **ALU encoding:** ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, MUL 10, PASSB 11.
- **Output defaults:** every output not listed for a state is 0.
- **FETCH:** `alu_src_a`=00, `alu_src_b`=10, ADD, `result_src`=10. `ir_write` and `pc_write` are asserted only in a cycle where `mem_ready`=1. Stay in FETCH until `mem_ready`=1, then go to DECODE.
- **DECODE:** `alu_src_a`=01, `alu_src_b`=01, ADD; `imm_src` set from the opcode. Next state by opcode:
  - 03 or 23 → MEM_ADDR
  - 33 → EXEC_R
  - 13 → EXEC_I
  - 6F → JAL
  - 67 → JALR_ADDR
  - 63 → BRANCH
  - 37 → LUI
  - 17 → AUIPC
  - anything else → TRAP, cause 01
  - Also TRAP, cause 01: branch funct3 010/011; R-type funct7 not in {00, 20, 01}; funct7=20 with funct3 not in {000, 101}.
- **MEM_ADDR:** `alu_src_a`=10, `alu_src_b`=01, ADD; `imm_src` = I for load, S for store. Next: MEM_READ (load) or MEM_WR (store).
- **MEM_READ:** `adr_src`=1, `result_src`=00. Wait for `mem_ready`, then go to MEM_WB.
- **MEM_WB:** `reg_write`=1, `result_src`=01. Next: FETCH.
- **MEM_WR:** `adr_src`=1; `mem_write`=1 every cycle in the state. Wait for `mem_ready`, then go to FETCH.
- **EXEC_R:** `alu_src_a`=10, `alu_src_b`=00; `alu_ctrl` decoded as follows:
  - funct3 000 → ADD, or SUB if funct7=20
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR
  - 101 → SRL, or SRA if funct7=20
  - 110 → OR; 111 → AND
  - Next: ALU_WB.
- **EXEC_I:** `alu_src_a`=10, `alu_src_b`=01, `imm_src`=I. Same decode as EXEC_R, except funct3=000 always gives ADD and funct7[5] selects SRAI. Next: ALU_WB.
- **ALU_WB:** `reg_write`=1, `result_src`=00. Next: FETCH.
- **JAL:** `pc_write`=1, `alu_src_a`=01, `alu_src_b`=10, ADD, `result_src`=00. Next: ALU_WB.
- **JALR_ADDR:** `alu_src_a`=10, `alu_src_b`=01, `imm_src`=I, ADD. Next: JALR_LINK.
- **JALR_LINK:** same outputs as JAL. Next: ALU_WB.
- **BRANCH:** `alu_src_a`=10, `alu_src_b`=00, SUB, `result_src`=00.
  - `branch` by funct3: 000 `zero`, 001 `!zero`, 100 `lt`, 101 `!lt`, 110 `ltu`, 111 `!ltu`.
  - Next: FETCH.
- **LUI:** `alu_src_b`=01, `imm_src`=U, PASSB. Next: ALU_WB.
- **AUIPC:** `alu_src_a`=01, `alu_src_b`=01, `imm_src`=U, ADD. Next: ALU_WB.
- **TRAP:** all enables 0; `trap`=1. Sticky; only `rst` leaves TRAP.
- **Wait counter:** cleared on entry to FETCH, MEM_READ or MEM_WR. Increments each cycle `mem_ready`=0.
  - If the count equals WAIT_MAX while `mem_ready`=0 (and WAIT_MAX≠0), go to TRAP with cause 10.
  - `mem_ready`=1 in that same cycle takes priority: no trap.

## Timing
- **Reset:** state=FETCH, counter=0, `trap_cause`=00. All outputs take their FETCH values; write enables stay 0 until `mem_ready`.
- **Outputs:** Moore from state, plus combinational dependence on `mem_ready` (FETCH) and on the flags (BRANCH).
- **Latency with `mem_ready` held at 1:**
  - R, I, LUI, AUIPC: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - JAL: 4 cycles
  - JALR: 5 cycles
- Each cycle of `mem_ready`=0 in a wait state adds one cycle.
- **Reset mid-instruction:** returns to FETCH immediately and asynchronously; no partial write is issued after `rst` falls.

## Configuration
- Macro `RV_MUL_EN`.
- **Defined:** R-type funct7=01 with funct3=000 decodes to MUL (`alu_ctrl`=10).
- **Undefined:** funct7=01 is illegal and goes to TRAP, cause 01; opcode 10 is never produced.

## Test plan
- **ADD:** `add` (0x33, funct7 00, funct3 000), `mem_ready`=1 → FETCH, DECODE, EXEC_R (`alu_ctrl`=0), ALU_WB (`reg_write`=1), back to FETCH after 4 cycles.
- **Load wait:** `lw` with `mem_ready` low for 3 cycles in MEM_READ → MEM_READ held 4 cycles, then MEM_WB with `result_src`=01; 8 cycles total.
- **Branches:** `bltu` with `ltu`=1 → `branch`=1 in BRANCH. `bge` with `lt`=1 → `branch`=0. funct3=010 → TRAP, cause 01.
- **Illegal opcode:** 0x7F → TRAP, `trap`=1, cause 01. Stays in TRAP for 20 cycles; `rst` low → FETCH, cause 00.
- **Timeout:** WAIT_MAX=15, `mem_ready` stuck at 0 in FETCH → TRAP at cycle 16 with cause 10. `mem_ready`=1 exactly at cycle 16 → DECODE, no trap.
- **MUL:** funct7=01, funct3=000 → `alu_ctrl`=10 with `RV_MUL_EN` defined; TRAP, cause 01 without it.
